// File: rtl/s100_extram_ctrl.sv
// s100_extram_ctrl: sequencer for an external asynchronous SRAM.
// Each access runs SETUP -> STROBE -> HOLD with parameterised cycle counts.
// Optional feature macro: EXTRAM_BANKSEL_EN adds a bank register whose value
// forms the upper bits of ram_adr.
module s100_extram_ctrl #(
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned SETUP_CYC   = 1,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned HOLD_CYC    = 1,
   parameter int unsigned BANK_W      = 2
) (
   input  logic                     clockIn,
   input  logic                     n_reset,
   input  logic                     req,
   input  logic                     wr,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic                     busy,
   output logic                     done,
`ifdef EXTRAM_BANKSEL_EN
   output logic [BANK_W+ADDR_W-1:0] ram_adr,
`else
   output logic [ADDR_W-1:0]        ram_adr,
`endif
   input  logic [DATA_W-1:0]        ram_din,
   output logic [DATA_W-1:0]        ram_dout,
   output logic                     ram_dout_oe,
   output logic                     ram_n_cs,
   output logic                     ram_n_oe,
   output logic                     ram_n_wr
`ifdef EXTRAM_BANKSEL_EN
   ,
   input  logic                     bank_wr,
   input  logic [BANK_W-1:0]        bank_in
`endif
);

   // Reject configurations with no setup or hold time, or an empty bank field
   if (SETUP_CYC < 1) begin : g_bad_setup
      $error("s100_extram_ctrl: SETUP_CYC must be >= 1");
   end
   if (HOLD_CYC < 1) begin : g_bad_hold
      $error("s100_extram_ctrl: HOLD_CYC must be >= 1");
   end
   if (BANK_W < 1) begin : g_bad_bank
      $error("s100_extram_ctrl: BANK_W must be >= 1");
   end

   localparam int unsigned LOAD_SH  = (SETUP_CYC > 0) ? SETUP_CYC - 1 : 0;
   localparam int unsigned LOAD_HD  = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
   localparam int unsigned MAX_A    = (LOAD_SH > LOAD_HD) ? LOAD_SH : LOAD_HD;
   localparam int unsigned MAX_LOAD = (MAX_A > WAIT_STATES) ? MAX_A : WAIT_STATES;
   localparam int unsigned CNT_W    = (MAX_LOAD < 1) ? 1 : $clog2(MAX_LOAD + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wr_q, wr_d;
   logic               accept, capture, done_d;
   logic               busy_d, cs_n_d, oe_n_d, wr_n_d, dout_oe_d;

`ifdef EXTRAM_BANKSEL_EN
   logic [BANK_W-1:0]  bank_q;

   // Bank register; an access latches the value held before this edge
   always_ff @(posedge clockIn or negedge n_reset) begin
      if (!n_reset)     bank_q <= '0;
      else if (bank_wr) bank_q <= bank_in;
   end
`endif

   // State, cycle counter and latched direction
   always_ff @(posedge clockIn or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
      end
   end

   // Next state, counter reload on state entry, and next pin values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      capture = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = SETUP;
               cnt_d   = CNT_W'(LOAD_SH);
               accept  = 1'b1;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = STROBE;
               cnt_d   = CNT_W'(WAIT_STATES);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = CNT_W'(LOAD_HD);
               capture = !wr_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      wr_d      = accept ? wr : wr_q;
      busy_d    = (state_d != IDLE);
      cs_n_d    = (state_d == IDLE);
      oe_n_d    = !((state_d == STROBE) && !wr_d);
      wr_n_d    = !((state_d == STROBE) && wr_d);
      dout_oe_d = wr_d && ((state_d == STROBE) || (state_d == HOLD));
   end

   // Registered SRAM pins and bus-side outputs
   always_ff @(posedge clockIn or negedge n_reset) begin
      if (!n_reset) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_n_cs    <= 1'b1;
         ram_n_oe    <= 1'b1;
         ram_n_wr    <= 1'b1;
         ram_dout_oe <= 1'b0;
         rdata       <= '0;
         ram_adr     <= '0;
         ram_dout    <= '0;
      end else begin
         busy        <= busy_d;
         done        <= done_d;
         ram_n_cs    <= cs_n_d;
         ram_n_oe    <= oe_n_d;
         ram_n_wr    <= wr_n_d;
         ram_dout_oe <= dout_oe_d;
         if (capture) rdata <= ram_din;
         if (accept) begin
`ifdef EXTRAM_BANKSEL_EN
            ram_adr  <= {bank_q, addr};
`else
            ram_adr  <= addr;
`endif
            ram_dout <= wdata;
         end
      end
   end

endmodule

// File: tb/tb_s100_extram_ctrl.sv
// Directed bench for s100_extram_ctrl: default instance plus a stretched-timing
// instance (SETUP_CYC=2, WAIT_STATES=3, HOLD_CYC=2).
`timescale 1ns/1ps
module tb_s100_extram_ctrl;

   logic        clockIn = 1'b0;
   logic        n_reset;
   logic        req, req2, wr;
   logic [18:0] addr;
   logic [7:0]  wdata, ram_din;

   logic [7:0]  u0_rdata, u0_dout, u1_rdata, u1_dout;
   logic        u0_busy, u0_done, u0_oe_en, u0_n_cs, u0_n_oe, u0_n_wr;
   logic        u1_busy, u1_done, u1_oe_en, u1_n_cs, u1_n_oe, u1_n_wr;
`ifdef EXTRAM_BANKSEL_EN
   logic [20:0] u0_adr, u1_adr;
   logic        bank_wr;
   logic [1:0]  bank_in;
`else
   logic [18:0] u0_adr, u1_adr;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clockIn = ~clockIn;

   s100_extram_ctrl u0 (
      .clockIn(clockIn), .n_reset(n_reset), .req(req), .wr(wr), .addr(addr),
      .wdata(wdata), .rdata(u0_rdata), .busy(u0_busy), .done(u0_done),
      .ram_adr(u0_adr), .ram_din(ram_din), .ram_dout(u0_dout),
      .ram_dout_oe(u0_oe_en), .ram_n_cs(u0_n_cs), .ram_n_oe(u0_n_oe),
      .ram_n_wr(u0_n_wr)
`ifdef EXTRAM_BANKSEL_EN
      , .bank_wr(bank_wr), .bank_in(bank_in)
`endif
   );

   s100_extram_ctrl #(.SETUP_CYC(2), .WAIT_STATES(3), .HOLD_CYC(2)) u1 (
      .clockIn(clockIn), .n_reset(n_reset), .req(req2), .wr(wr), .addr(addr),
      .wdata(wdata), .rdata(u1_rdata), .busy(u1_busy), .done(u1_done),
      .ram_adr(u1_adr), .ram_din(ram_din), .ram_dout(u1_dout),
      .ram_dout_oe(u1_oe_en), .ram_n_cs(u1_n_cs), .ram_n_oe(u1_n_oe),
      .ram_n_wr(u1_n_wr)
`ifdef EXTRAM_BANKSEL_EN
      , .bank_wr(1'b0), .bank_in(2'b00)
`endif
   );

   task automatic tick;
      @(posedge clockIn);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_reset = 1'b0; req = 1'b0; req2 = 1'b0; wr = 1'b0;
      addr = '0; wdata = '0; ram_din = '0;
`ifdef EXTRAM_BANKSEL_EN
      bank_wr = 1'b0; bank_in = 2'b00;
`endif
      repeat (2) tick;
      n_reset = 1'b1;
      tick;
      chk("rst_cs",    32'(u0_n_cs), 1);
      chk("rst_oe",    32'(u0_n_oe), 1);
      chk("rst_wr",    32'(u0_n_wr), 1);
      chk("rst_doe",   32'(u0_oe_en), 0);
      chk("rst_busy",  32'(u0_busy), 0);
      chk("rst_done",  32'(u0_done), 0);
      chk("rst_rdata", 32'(u0_rdata), 0);
      chk("rst_adr",   32'(u0_adr), 0);

      // read at 0x5A5A5
      addr = 19'h5A5A5; ram_din = 8'hC3; wr = 1'b0; req = 1'b1;
      tick; req = 1'b0;
      chk("rd_c1_cs",   32'(u0_n_cs), 0);
      chk("rd_c1_busy", 32'(u0_busy), 1);
      chk("rd_c1_adr",  32'(u0_adr), 32'h5A5A5);
      chk("rd_c1_oe",   32'(u0_n_oe), 1);
      tick;
      chk("rd_c2_oe",   32'(u0_n_oe), 0);
      chk("rd_c2_wr",   32'(u0_n_wr), 1);
      chk("rd_c2_doe",  32'(u0_oe_en), 0);
      tick;
      chk("rd_c3_oe",   32'(u0_n_oe), 0);
      chk("rd_c3_rdata", 32'(u0_rdata), 0);
      tick;
      chk("rd_c4_oe",   32'(u0_n_oe), 1);
      chk("rd_c4_cs",   32'(u0_n_cs), 0);
      chk("rd_c4_busy", 32'(u0_busy), 1);
      chk("rd_c4_rdata", 32'(u0_rdata), 32'hC3);
      chk("rd_c4_done", 32'(u0_done), 0);
      tick;
      chk("rd_c5_done", 32'(u0_done), 1);
      chk("rd_c5_busy", 32'(u0_busy), 0);
      chk("rd_c5_cs",   32'(u0_n_cs), 1);
      tick;
      chk("rd_c6_done", 32'(u0_done), 0);
      chk("rd_c6_adr",  32'(u0_adr), 32'h5A5A5);

      // write 0x7E at 0x12345
      ram_din = 8'h55; addr = 19'h12345; wdata = 8'h7E; wr = 1'b1; req = 1'b1;
      tick; req = 1'b0;
      chk("wr_c1_cs",  32'(u0_n_cs), 0);
      chk("wr_c1_wr",  32'(u0_n_wr), 1);
      chk("wr_c1_doe", 32'(u0_oe_en), 0);
      tick;
      chk("wr_c2_wr",  32'(u0_n_wr), 0);
      chk("wr_c2_doe", 32'(u0_oe_en), 1);
      chk("wr_c2_dout", 32'(u0_dout), 32'h7E);
      chk("wr_c2_oe",  32'(u0_n_oe), 1);
      tick;
      chk("wr_c3_wr",  32'(u0_n_wr), 0);
      chk("wr_c3_oe",  32'(u0_n_oe), 1);
      tick;
      chk("wr_c4_wr",  32'(u0_n_wr), 1);
      chk("wr_c4_doe", 32'(u0_oe_en), 1);
      chk("wr_c4_oe",  32'(u0_n_oe), 1);
      tick;
      chk("wr_c5_doe", 32'(u0_oe_en), 0);
      chk("wr_c5_done", 32'(u0_done), 1);
      chk("wr_c5_rdata", 32'(u0_rdata), 32'hC3);
      tick;

      // stretched timing on u1: cs low 1-8, strobe 3-6, done at 9
      ram_din = 8'hA7; wr = 1'b0; addr = 19'h00ABC; req2 = 1'b1;
      tick; req2 = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         chk($sformatf("st_c%0d_oe", c),   32'(u1_n_oe), (c >= 3 && c <= 6) ? 0 : 1);
         chk($sformatf("st_c%0d_cs", c),   32'(u1_n_cs), (c >= 1 && c <= 8) ? 0 : 1);
         chk($sformatf("st_c%0d_busy", c), 32'(u1_busy), (c >= 1 && c <= 8) ? 1 : 0);
         chk($sformatf("st_c%0d_done", c), 32'(u1_done), (c == 9) ? 1 : 0);
         if (c == 6) chk("st_c6_rdata", 32'(u1_rdata), 0);
         if (c == 7) chk("st_c7_rdata", 32'(u1_rdata), 32'hA7);
         tick;
      end

      // reset asserted during write strobe
      wr = 1'b1; wdata = 8'h3C; addr = 19'h00007; req = 1'b1;
      tick; req = 1'b0;
      tick;
      chk("ab_c2_wr", 32'(u0_n_wr), 0);
      #2 n_reset = 1'b0;
      #1;
      chk("ab_wr",   32'(u0_n_wr), 1);
      chk("ab_cs",   32'(u0_n_cs), 1);
      chk("ab_doe",  32'(u0_oe_en), 0);
      chk("ab_busy", 32'(u0_busy), 0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("ab_nodone", 32'(u0_done), 0);
      end
      n_reset = 1'b1;
      tick;
      chk("ab_nodone_rel", 32'(u0_done), 0);
      wr = 1'b0; ram_din = 8'h96; addr = 19'h00011; req = 1'b1;
      tick; req = 1'b0;
      chk("ab_rd_c1_cs", 32'(u0_n_cs), 0);
      tick; tick; tick;
      chk("ab_rd_c4_rdata", 32'(u0_rdata), 32'h96);
      tick;
      chk("ab_rd_c5_done", 32'(u0_done), 1);
      tick;

      // req pulse while busy is dropped
      addr = 19'h00022; ram_din = 8'h5F; req = 1'b1;
      tick; req = 1'b0;
      tick; req = 1'b1;
      tick; req = 1'b0;
      tick;
      tick;
      chk("ig_c5_done",  32'(u0_done), 1);
      chk("ig_c5_rdata", 32'(u0_rdata), 32'h5F);
      tick;
      chk("ig_c6_cs",   32'(u0_n_cs), 1);
      chk("ig_c6_busy", 32'(u0_busy), 0);

      // req held high: second access accepted in the done cycle
      req = 1'b1;
      tick; tick; tick; tick;
      chk("bb_c4_busy", 32'(u0_busy), 1);
      tick;
      chk("bb_c5_done", 32'(u0_done), 1);
      chk("bb_c5_cs",   32'(u0_n_cs), 1);
      chk("bb_c5_busy", 32'(u0_busy), 0);
      tick; req = 1'b0;
      chk("bb_c6_cs",   32'(u0_n_cs), 0);
      chk("bb_c6_busy", 32'(u0_busy), 1);
      chk("bb_c6_done", 32'(u0_done), 0);
      tick; tick; tick; tick;
      chk("bb_c10_done", 32'(u0_done), 1);
      tick;
      chk("bb_c11_done", 32'(u0_done), 0);
      chk("bb_c11_cs",   32'(u0_n_cs), 1);

`ifdef EXTRAM_BANKSEL_EN
      // bank bits latched at acceptance
      bank_wr = 1'b1; bank_in = 2'b10;
      tick; bank_wr = 1'b0;
      addr = 19'h00010; req = 1'b1;
      tick; req = 1'b0;
      chk("bk_c1_adr", 32'(u0_adr), 32'h100010);
      bank_wr = 1'b1; bank_in = 2'b11;
      tick; bank_wr = 1'b0;
      chk("bk_c2_adr", 32'(u0_adr), 32'h100010);
      tick; tick; tick;
      chk("bk_c5_done", 32'(u0_done), 1);
      tick;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
